line_memory: RTL
================

LINE_MEMORY -- requirements
Module: line_memory

Interface
REQ-001 Parameter BLOCK_SIZE, default 64: line size in bytes; line width is 512 bits.
REQ-002 Parameter NO_LINES, default 256: number of stored lines.
REQ-003 Parameter LATENCY, default 4: cycles from request acceptance to response, legal range 1..15.
REQ-004 Port clk  input  1: single clock; all logic is on its rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 Port req_valid  input  1: the cache presents a line request.
REQ-007 Port req_ready  output  1: the block accepts a request on this cycle.
REQ-008 Port req_write  input  1: 1 = writeback (evict), 0 = line fill (allocate read).
REQ-009 Port req_addr  input  32: byte address; bits [5:0] are the offset and bits [13:6] are the line index.
REQ-010 Port req_wdata  input  512: writeback line data.
REQ-011 Port rsp_valid  output  1: a response is present.
REQ-012 Port rsp_ready  input  1: the cache consumes the response.
REQ-013 Port rsp_rdata  output  512: fill data; 0 for write responses.
REQ-014 Port rsp_err  output  1: the request was rejected as misaligned.
REQ-015 Port rd_count / wr_count  output  16 each: count of completed fills and writebacks.

Function
REQ-016 The block SHALL serve one outstanding request at a time.
- States: IDLE, WAIT, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE.
- In IDLE, req_valid=1 is an acceptance.
- On acceptance, capture write flag, line index, wdata and misalignment; load the latency counter with LATENCY-1; go to WAIT.
REQ-018 In WAIT, the counter SHALL decrement each cycle.
- At count 0 the block SHALL perform the access, drive the response registers and go to RESP.
- Result: rsp_valid rises exactly LATENCY cycles after the acceptance edge.
REQ-019 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL stay stable until the cycle rsp_valid && rsp_ready.
- The block then returns to IDLE with rsp_valid=0.
- req_ready is 1 no earlier than the next cycle; there is no back-to-back acceptance in the response cycle.
REQ-020 Write access: store wdata at the index, set the line's written flag, increment wr_count.
REQ-021 Read access of a written line: return its stored data.
- Read access of a never-written line: return {16{32'hCAFEBABE}}.
- Increment rd_count.
REQ-022 A request with req_addr[5:0] != 0 SHALL complete with rsp_err=1 and rsp_rdata=0.
- It performs no storage access and no counter change.
REQ-023 Address bits above the index SHALL be ignored.
- Lines alias modulo NO_LINES (the index wraps around).
REQ-024 The counters SHALL saturate at 16'hFFFF.
REQ-025 req_addr, req_write and req_wdata SHALL be ignored outside the acceptance cycle.

Reset
REQ-026 Asserting rst_n low SHALL immediately force the following, regardless of state, including mid-WAIT or mid-RESP:
- state IDLE, req_ready 0 during reset;
- rsp_valid 0, rsp_err 0, rsp_rdata 0;
- counters 0;
- all written flags 0.
REQ-027 Line data contents are not reset; cleared written flags make every line read as the fill pattern.
REQ-028 An in-flight request at reset SHALL be dropped with no response and no storage update.
REQ-029 req_ready SHALL be 1 on the first clock edge after rst_n deasserts.

Structure
REQ-030 A shared package SHALL hold:
- state encoding IDLE/WAIT/RESP;
- LINE_BITS=512;
- FILL_PATTERN=32'hCAFEBABE;
- the offset and index width derivations.
REQ-031 Storage SHALL be one sub-module, line_memory_array.
- Synchronous write port; registered read port.
- Holds the line data plus the written flags.
- The FSM, latency counter and counters stay in line_memory.

Verification
REQ-032 Reset, then read addr {index 5, offset 0} -> rsp_valid exactly 4 cycles after acceptance, rsp_rdata={16{CAFEBABE}}, rd_count=1.
REQ-033 Write 32'hDADADADA to index 5, then read index 5 -> write response rsp_rdata=0, rsp_err=0; read returns the zero-extended DADADADA; wr_count=1, rd_count=1.
REQ-034 Request addr 0x00000144 (offset 4) -> rsp_err=1, rsp_rdata=0, counters unchanged, storage unchanged.
REQ-035 Hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid and data stay stable and req_ready stays 0 while a second req_valid is held; that request is accepted only after the handshake.
REQ-036 Write index 7 via addr {tag 100, 7, 0}, read via addr {tag 200, 7, 0} -> aliased data is returned.
REQ-037 Assert rst_n low 2 cycles into WAIT of a write -> no response; a later read of that index returns CAFEBABE, wr_count=0.

Source files
------------

// File: rtl/line_memory_pkg.sv
// Shared definitions for the line memory: FSM states, line geometry and fill pattern.
package line_memory_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    localparam int unsigned LINE_BITS    = 512;
    localparam logic [31:0] FILL_PATTERN = 32'hCAFEBABE;
    localparam int unsigned CNT_W        = 4;  // holds LATENCY-1 for LATENCY up to 15

    // Byte-offset bits within one line.
    function automatic int unsigned offset_bits(input int unsigned block_size);
        return $clog2(block_size);
    endfunction

    // Line-index bits selecting one of the stored lines.
    function automatic int unsigned index_bits(input int unsigned no_lines);
        return $clog2(no_lines);
    endfunction

endpackage

// File: rtl/line_memory_array.sv
// Line storage: data array (not reset), per-line written flags, registered read port.
module line_memory_array
    import line_memory_pkg::*;
#(
    parameter int unsigned NO_LINES = 256,
    parameter int unsigned INDEX_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [INDEX_W-1:0]   idx,
    input  logic [LINE_BITS-1:0] wr_data,
    output logic [LINE_BITS-1:0] rd_data
);

    logic [LINE_BITS-1:0] mem_q [NO_LINES];
    logic [NO_LINES-1:0]  written_q;
    logic [LINE_BITS-1:0] rd_data_q;

    // Line data: plain synchronous write, contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx] <= wr_data;
        end
    end

    // Written flags: cleared by reset so every line reads back as the fill pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written_q <= '0;
        end else if (wr_en) begin
            written_q[idx] <= 1'b1;
        end
    end

    // Registered read; only updated on a read access so the response stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= written_q[idx] ? mem_q[idx] : {(LINE_BITS / 32){FILL_PATTERN}};
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/line_memory.sv
// Single-outstanding line memory with fixed access latency and fill/writeback counters.
module line_memory
    import line_memory_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = 64,
    parameter int unsigned NO_LINES   = 256,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [31:0]          req_addr,
    input  logic [LINE_BITS-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [LINE_BITS-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count
);

    localparam int unsigned OFFSET_W = offset_bits(BLOCK_SIZE);
    localparam int unsigned INDEX_W  = index_bits(NO_LINES);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 write_q;
    logic                 err_q;
    logic [INDEX_W-1:0]   idx_q;
    logic [LINE_BITS-1:0] wdata_q;
    logic [15:0]          rd_count_q, wr_count_q;
    logic [LINE_BITS-1:0] arr_rdata;
    logic                 accept, access, arr_wr_en, arr_rd_en;
    logic                 unused_addr;

    // Upper address bits are tag and deliberately ignored: lines alias.
    assign unused_addr = ^req_addr;

    // Gate with rst_n so the block never looks ready while held in reset.
    assign req_ready = rst_n && (state_q == StIdle);
    assign accept    = req_valid && req_ready;
    assign access    = (state_q == StWait) && (cnt_q == '0);
    assign arr_wr_en = access && write_q && !err_q;
    assign arr_rd_en = access && !write_q && !err_q;

    // Next-state and latency counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StWait;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture; held unchanged until the next acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            write_q <= req_write;
            err_q   <= (req_addr[OFFSET_W-1:0] != '0);
            idx_q   <= req_addr[OFFSET_W +: INDEX_W];
            wdata_q <= req_wdata;
        end
    end

    // Saturating completion counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            if (arr_rd_en && (rd_count_q != 16'hFFFF)) begin
                rd_count_q <= rd_count_q + 16'd1;
            end
            if (arr_wr_en && (wr_count_q != 16'hFFFF)) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

    line_memory_array #(
        .NO_LINES (NO_LINES),
        .INDEX_W  (INDEX_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (arr_wr_en),
        .rd_en   (arr_rd_en),
        .idx     (idx_q),
        .wr_data (wdata_q),
        .rd_data (arr_rdata)
    );

    // The array read register doubles as the response data register.
    assign rsp_valid = (state_q == StResp);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !write_q && !err_q) ? arr_rdata : '0;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;

endmodule
